// File: rtl/instr_encoder.sv
// Frost32 instruction encoder: packs and range-checks field-level requests into 32-bit words.
// Optional FROST32_ENC_WIDE_IMM_EN adds the two-word cpyhi/orri constant-load expansion.
module instr_encoder (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [3:0]  in_group,
  input  logic [3:0]  in_opcode,
  input  logic [3:0]  in_ra,
  input  logic [3:0]  in_rb,
  input  logic [3:0]  in_rc,
  input  logic [31:0] in_imm,
  input  logic        in_wide,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_word,
  output logic        err_pulse,
  output logic [15:0] word_cnt
);

`ifdef FROST32_ENC_WIDE_IMM_EN
  typedef enum logic [0:0] {S_RUN, S_WIDE_LO} state_t;
`else
  typedef enum logic [0:0] {S_RUN} state_t;
`endif

  state_t      r_state;
  logic        r_out_valid;
  logic [31:0] r_out_word;
  logic        r_err_pulse;
  logic [15:0] r_word_cnt;

  logic        w_accept;
  logic        w_handoff;
  logic        w_fits16;
  logic        w_fits12;
  logic        w_hi_zero;
  logic        w_signed_op;
  logic        w_legal;
  logic [31:0] w_enc;

  assign w_handoff = r_out_valid && out_ready;
  assign in_ready  = (r_state == S_RUN) && (!r_out_valid || out_ready);
  assign w_accept  = in_valid && in_ready;

  assign out_valid = r_out_valid;
  assign out_word  = r_out_word;
  assign err_pulse = r_err_pulse;
  assign word_cnt  = r_word_cnt;

  assign w_fits16    = (in_imm[31:15] == {17{in_imm[15]}});
  assign w_fits12    = (in_imm[31:11] == {21{in_imm[11]}});
  assign w_hi_zero   = (in_imm[31:16] == 16'h0000);
  assign w_signed_op = (in_opcode == 4'd3) || (in_opcode == 4'd5) || (in_opcode == 4'd14);

  always_comb begin
    w_legal = 1'b0;
    w_enc   = 32'h0000_0000;
    case (in_group)
      4'd0, 4'd3, 4'd4: begin
        w_enc   = {in_group, in_ra, in_rb, in_rc, 12'h000, in_opcode};
        w_legal = (in_group == 4'd0) ? (in_opcode < 4'd14) : (in_opcode < 4'd10);
      end
      4'd1: begin
        w_enc   = {in_group, in_ra, in_rb, in_opcode, in_imm[15:0]};
        w_legal = w_signed_op ? w_fits16 : w_hi_zero;
      end
      4'd2: begin
        w_enc   = {in_group, in_ra, in_rb, in_opcode, in_imm[15:0]};
        w_legal = (in_opcode < 4'd10) && w_fits16;
      end
      4'd5: begin
        // Upper half of group 5 carries an imm12 in place of rc; lower half carries rc only.
        if (in_opcode[3]) begin
          w_enc   = {in_group, in_ra, in_rb, 4'h0, in_imm[11:0], in_opcode};
          w_legal = w_fits12;
        end else begin
          w_enc   = {in_group, in_ra, in_rb, in_rc, 12'h000, in_opcode};
          w_legal = 1'b1;
        end
      end
      default: begin
        w_enc   = 32'h0000_0000;
        w_legal = 1'b0;
      end
    endcase
  end

`ifdef FROST32_ENC_WIDE_IMM_EN
  logic [31:0] r_lo_word;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_RUN;
      r_out_valid <= 1'b0;
      r_out_word  <= 32'h0000_0000;
      r_err_pulse <= 1'b0;
      r_word_cnt  <= 16'h0000;
      r_lo_word   <= 32'h0000_0000;
    end else begin
      r_err_pulse <= 1'b0;
      if (w_handoff) r_word_cnt <= r_word_cnt + 16'd1;
      case (r_state)
        S_RUN: begin
          if (w_accept) begin
            if (in_wide) begin
              r_out_word  <= {4'd1, in_ra, 4'd0, 4'd15, in_imm[31:16]};
              r_out_valid <= 1'b1;
              r_lo_word   <= {4'd1, in_ra, in_ra, 4'd8, in_imm[15:0]};
              r_state     <= S_WIDE_LO;
            end else if (w_legal) begin
              r_out_word  <= w_enc;
              r_out_valid <= 1'b1;
            end else begin
              r_out_valid <= 1'b0;
              r_err_pulse <= 1'b1;
            end
          end else if (w_handoff) begin
            r_out_valid <= 1'b0;
          end
        end
        S_WIDE_LO: begin
          if (w_handoff) begin
            r_out_word  <= r_lo_word;
            r_out_valid <= 1'b1;
            r_state     <= S_RUN;
          end
        end
        default: r_state <= S_RUN;
      endcase
    end
  end
`else
  logic w_unused_wide;
  assign w_unused_wide = in_wide;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_RUN;
      r_out_valid <= 1'b0;
      r_out_word  <= 32'h0000_0000;
      r_err_pulse <= 1'b0;
      r_word_cnt  <= 16'h0000;
    end else begin
      r_state     <= S_RUN;
      r_err_pulse <= 1'b0;
      if (w_handoff) r_word_cnt <= r_word_cnt + 16'd1;
      if (w_accept) begin
        if (w_legal) begin
          r_out_word  <= w_enc;
          r_out_valid <= 1'b1;
        end else begin
          r_out_valid <= 1'b0;
          r_err_pulse <= 1'b1;
        end
      end else if (w_handoff) begin
        r_out_valid <= 1'b0;
      end
    end
  end
`endif

endmodule

// File: tb/tb_instr_encoder.sv
// Testbench for instr_encoder: table-driven encode/legality vectors plus
// hand-written backpressure, back-to-back, wide-load and reset sequences.
module tb_instr_encoder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_group;
  logic [3:0]  in_opcode;
  logic [3:0]  in_ra;
  logic [3:0]  in_rb;
  logic [3:0]  in_rc;
  logic [31:0] in_imm;
  logic        in_wide;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_word;
  logic        err_pulse;
  logic [15:0] word_cnt;

  int checks = 0;
  int errors = 0;
  int expCnt = 0;

  typedef struct {
    logic [3:0]  grp;
    logic [3:0]  op;
    logic [3:0]  ra;
    logic [3:0]  rb;
    logic [3:0]  rc;
    logic [31:0] imm;
    logic        wide;
    logic        expErr;
    logic [31:0] expWord;
  } vec_t;

  vec_t vecs[$];

  instr_encoder dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_group  (in_group),
    .in_opcode (in_opcode),
    .in_ra     (in_ra),
    .in_rb     (in_rb),
    .in_rc     (in_rc),
    .in_imm    (in_imm),
    .in_wide   (in_wide),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_word  (out_word),
    .err_pulse (err_pulse),
    .word_cnt  (word_cnt)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(input logic [3:0] grp, input logic [3:0] op,
                              input logic [3:0] ra, input logic [3:0] rb, input logic [3:0] rc,
                              input logic [31:0] imm, input logic wide,
                              input logic expErr, input logic [31:0] expWord);
    vec_t v;
    v.grp = grp; v.op = op; v.ra = ra; v.rb = rb; v.rc = rc;
    v.imm = imm; v.wide = wide; v.expErr = expErr; v.expWord = expWord;
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    in_group  = v.grp;
    in_opcode = v.op;
    in_ra     = v.ra;
    in_rb     = v.rb;
    in_rc     = v.rc;
    in_imm    = v.imm;
    in_wide   = v.wide;
    in_valid  = 1'b1;
  endtask

  // Holds in_valid until in_ready is seen, then lets the accepting edge pass.
  task automatic waitAccept(input string name);
    int n = 0;
    #1;
    while (!in_ready && n < 20) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("[TB] FAIL %s_accept_timeout: got in_ready=0 expected in_ready=1", name);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_group  = 4'd0;
    in_opcode = 4'd0;
    in_ra     = 4'd0;
    in_rb     = 4'd0;
    in_rc     = 4'd0;
    in_imm    = 32'd0;
    in_wide   = 1'b0;
    out_ready = 1'b1;

    // Table: grp op ra rb rc imm wide expErr expWord
    vecs.push_back(mk(4'd0, 4'd0,  4'd3,  4'd4,  4'd5, 32'hFFFF_FFFF, 1'b0, 1'b0, 32'h0345_0000));
    vecs.push_back(mk(4'd1, 4'd0,  4'd1,  4'd2,  4'd7, 32'h0000_1234, 1'b0, 1'b0, 32'h1120_1234));
    vecs.push_back(mk(4'd1, 4'd0,  4'd1,  4'd2,  4'd7, 32'h0001_0000, 1'b0, 1'b1, 32'h0));
    vecs.push_back(mk(4'd5, 4'd8,  4'd1,  4'd2,  4'd9, 32'hFFFF_FFFC, 1'b0, 1'b0, 32'h5120_FFC8));
    vecs.push_back(mk(4'd5, 4'd8,  4'd1,  4'd2,  4'd9, 32'h0000_0800, 1'b0, 1'b1, 32'h0));
    vecs.push_back(mk(4'd5, 4'd8,  4'd1,  4'd2,  4'd9, 32'h0000_07FF, 1'b0, 1'b0, 32'h5120_7FF8));
    vecs.push_back(mk(4'd5, 4'd15, 4'd1,  4'd2,  4'd9, 32'hFFFF_F800, 1'b0, 1'b0, 32'h5120_800F));
    vecs.push_back(mk(4'd5, 4'd3,  4'd1,  4'd2,  4'd9, 32'h0000_0123, 1'b0, 1'b0, 32'h5129_0003));
    vecs.push_back(mk(4'd1, 4'd3,  4'd1,  4'd2,  4'd0, 32'hFFFF_8000, 1'b0, 1'b0, 32'h1123_8000));
    vecs.push_back(mk(4'd1, 4'd3,  4'd1,  4'd2,  4'd0, 32'h0000_8000, 1'b0, 1'b1, 32'h0));
    vecs.push_back(mk(4'd1, 4'd14, 4'd1,  4'd2,  4'd0, 32'hFFFF_7FFF, 1'b0, 1'b1, 32'h0));
    vecs.push_back(mk(4'd1, 4'd0,  4'd1,  4'd2,  4'd0, 32'h0000_8000, 1'b0, 1'b0, 32'h1120_8000));
    vecs.push_back(mk(4'd1, 4'd15, 4'd6,  4'd7,  4'd0, 32'h0000_FFFF, 1'b0, 1'b0, 32'h167F_FFFF));
    vecs.push_back(mk(4'd2, 4'd9,  4'd4,  4'd5,  4'd0, 32'hFFFF_8000, 1'b0, 1'b0, 32'h2459_8000));
    vecs.push_back(mk(4'd2, 4'd10, 4'd4,  4'd5,  4'd0, 32'h0000_0001, 1'b0, 1'b1, 32'h0));
    vecs.push_back(mk(4'd2, 4'd0,  4'd4,  4'd5,  4'd0, 32'h0000_8000, 1'b0, 1'b1, 32'h0));
    vecs.push_back(mk(4'd0, 4'd13, 4'd1,  4'd2,  4'd3, 32'h0,         1'b0, 1'b0, 32'h0123_000D));
    vecs.push_back(mk(4'd0, 4'd14, 4'd1,  4'd2,  4'd3, 32'h0,         1'b0, 1'b1, 32'h0));
    vecs.push_back(mk(4'd3, 4'd9,  4'd15, 4'd14, 4'd13, 32'h0,        1'b0, 1'b0, 32'h3FED_0009));
    vecs.push_back(mk(4'd4, 4'd10, 4'd1,  4'd2,  4'd3, 32'h0,         1'b0, 1'b1, 32'h0));
    vecs.push_back(mk(4'd6, 4'd0,  4'd1,  4'd2,  4'd3, 32'h0,         1'b0, 1'b1, 32'h0));
    vecs.push_back(mk(4'd15, 4'd0, 4'd1,  4'd2,  4'd3, 32'h0,         1'b0, 1'b1, 32'h0));
`ifndef FROST32_ENC_WIDE_IMM_EN
    vecs.push_back(mk(4'd0, 4'd0,  4'd3,  4'd4,  4'd5, 32'hDEAD_BEEF, 1'b1, 1'b0, 32'h0345_0000));
    vecs.push_back(mk(4'd9, 4'd0,  4'd7,  4'd0,  4'd0, 32'hDEAD_BEEF, 1'b1, 1'b1, 32'h0));
`endif

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_out_valid", {31'd0, out_valid}, 32'd0);
    checkOutput("rst_out_word", out_word, 32'd0);
    checkOutput("rst_err_pulse", {31'd0, err_pulse}, 32'd0);
    checkOutput("rst_word_cnt", {16'd0, word_cnt}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checkOutput("rst_in_ready", {31'd0, in_ready}, 32'd1);

    // Table-driven vectors with out_ready held high
    foreach (vecs[i]) begin
      @(negedge clk);
      applyStimulus(vecs[i]);
      waitAccept($sformatf("v%0d", i));
      checkOutput($sformatf("v%0d_err_pulse", i), {31'd0, err_pulse}, {31'd0, vecs[i].expErr});
      checkOutput($sformatf("v%0d_out_valid", i), {31'd0, out_valid}, {31'd0, !vecs[i].expErr});
      if (!vecs[i].expErr) checkOutput($sformatf("v%0d_out_word", i), out_word, vecs[i].expWord);
      checkOutput($sformatf("v%0d_word_cnt", i), {16'd0, word_cnt}, expCnt);
      if (!vecs[i].expErr) expCnt++;
    end
    @(posedge clk);
    #1;
    checkOutput("tbl_final_cnt", {16'd0, word_cnt}, expCnt);
    checkOutput("tbl_final_valid", {31'd0, out_valid}, 32'd0);

    // Backpressure: sub stalled 5 cycles while a second request waits
    @(negedge clk);
    out_ready = 1'b0;
    applyStimulus(mk(4'd0, 4'd1, 4'd3, 4'd4, 4'd5, 32'h0, 1'b0, 1'b0, 32'h0));
    waitAccept("bp_sub");
    checkOutput("bp_word", out_word, 32'h0345_0001);
    applyStimulus(mk(4'd0, 4'd0, 4'd3, 4'd4, 4'd5, 32'h0, 1'b0, 1'b0, 32'h0));
    for (int c = 0; c < 5; c++) begin
      @(posedge clk);
      #1;
      checkOutput($sformatf("bp_hold%0d_word", c), out_word, 32'h0345_0001);
      checkOutput($sformatf("bp_hold%0d_valid", c), {31'd0, out_valid}, 32'd1);
      checkOutput($sformatf("bp_hold%0d_in_ready", c), {31'd0, in_ready}, 32'd0);
      checkOutput($sformatf("bp_hold%0d_cnt", c), {16'd0, word_cnt}, expCnt);
    end
    @(negedge clk);
    out_ready = 1'b1;
    #1;
    checkOutput("bp_release_in_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    expCnt++;
    checkOutput("bp_b2b_word", out_word, 32'h0345_0000);
    checkOutput("bp_b2b_valid", {31'd0, out_valid}, 32'd1);
    checkOutput("bp_b2b_cnt", {16'd0, word_cnt}, expCnt);
    @(posedge clk);
    #1;
    expCnt++;
    checkOutput("bp_drain_valid", {31'd0, out_valid}, 32'd0);
    checkOutput("bp_drain_cnt", {16'd0, word_cnt}, expCnt);

    // Illegal request accepted in the same cycle as a handoff
    @(negedge clk);
    applyStimulus(mk(4'd0, 4'd2, 4'd1, 4'd1, 4'd1, 32'h0, 1'b0, 1'b0, 32'h0));
    waitAccept("hx_legal");
    checkOutput("hx_word", out_word, 32'h0111_0002);
    applyStimulus(mk(4'd6, 4'd0, 4'd1, 4'd1, 4'd1, 32'h0, 1'b0, 1'b1, 32'h0));
    checkOutput("hx_in_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    expCnt++;
    checkOutput("hx_valid_drop", {31'd0, out_valid}, 32'd0);
    checkOutput("hx_err_pulse", {31'd0, err_pulse}, 32'd1);
    checkOutput("hx_cnt", {16'd0, word_cnt}, expCnt);
    @(posedge clk);
    #1;
    checkOutput("hx_err_one_cycle", {31'd0, err_pulse}, 32'd0);
    checkOutput("hx_cnt_after", {16'd0, word_cnt}, expCnt);

`ifdef FROST32_ENC_WIDE_IMM_EN
    // Wide constant load expands to cpyhi then orri
    @(negedge clk);
    applyStimulus(mk(4'd9, 4'd3, 4'd7, 4'd2, 4'd3, 32'hDEAD_BEEF, 1'b1, 1'b0, 32'h0));
    waitAccept("wide");
    checkOutput("wide_w1", out_word, 32'h170F_DEAD);
    checkOutput("wide_w1_valid", {31'd0, out_valid}, 32'd1);
    checkOutput("wide_in_ready_lo", {31'd0, in_ready}, 32'd0);
    checkOutput("wide_err", {31'd0, err_pulse}, 32'd0);
    @(posedge clk);
    #1;
    expCnt++;
    checkOutput("wide_w2", out_word, 32'h1778_BEEF);
    checkOutput("wide_w2_valid", {31'd0, out_valid}, 32'd1);
    checkOutput("wide_in_ready_run", {31'd0, in_ready}, 32'd1);
    checkOutput("wide_cnt1", {16'd0, word_cnt}, expCnt);
    @(posedge clk);
    #1;
    expCnt++;
    checkOutput("wide_done_valid", {31'd0, out_valid}, 32'd0);
    checkOutput("wide_cnt2", {16'd0, word_cnt}, expCnt);
`endif

    // Reset while a word is pending (in S_WIDE_LO when the wide load is built in)
    @(negedge clk);
    out_ready = 1'b0;
`ifdef FROST32_ENC_WIDE_IMM_EN
    applyStimulus(mk(4'd0, 4'd0, 4'd7, 4'd0, 4'd0, 32'h1234_5678, 1'b1, 1'b0, 32'h0));
`else
    applyStimulus(mk(4'd0, 4'd0, 4'd3, 4'd4, 4'd5, 32'h0, 1'b0, 1'b0, 32'h0));
`endif
    waitAccept("rs");
    checkOutput("rs_pending_valid", {31'd0, out_valid}, 32'd1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checkOutput("rs_valid", {31'd0, out_valid}, 32'd0);
    checkOutput("rs_word", out_word, 32'd0);
    checkOutput("rs_err", {31'd0, err_pulse}, 32'd0);
    checkOutput("rs_cnt", {16'd0, word_cnt}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    #1;
    checkOutput("rs_in_ready", {31'd0, in_ready}, 32'd1);
    for (int c = 0; c < 3; c++) begin
      @(posedge clk);
      #1;
      checkOutput($sformatf("rs_no_orri%0d", c), {31'd0, out_valid}, 32'd0);
      checkOutput($sformatf("rs_cnt%0d", c), {16'd0, word_cnt}, 32'd0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
